// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage feeding decode.
//
// Owns the fetch PC and issues word reads to instruction memory over a
// req/gnt handshake with in-order rvalid responses of variable latency.
// Returned words are buffered in a prefetch FIFO. One instruction per cycle is
// presented to decode on pc_o/inst_o. An empty slot is presented as inst_o = 0,
// which decodes as a NOP.
//
// Parameters
//   RESET_PC    PC of the first fetch after reset release
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2); also the maximum number
//               of outstanding requests
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   stall_i               decode holds, so pc_o/inst_o are frozen
//   flush_i               redirect to redirect_pc_i and discard all fetch state
//   redirect_pc_i         new word-aligned PC, sampled while flush_i = 1
//   imem_req_o/addr_o     fetch request and byte address
//   imem_gnt_i            request accepted when imem_req_o & imem_gnt_i
//   imem_rvalid_i/rdata_i read response (in request order)
//   pc_o, inst_o          instruction presented to decode
//
// Optional feature (macro IF_PERF_CNT_EN)
//   Adds perf_fetch_o (granted requests) and perf_bubble_o (unstalled cycles
//   in which a NOP was presented). Both counters saturate at all-ones and are
//   cleared only by reset.
// ----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_bubble_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;     // PC of the next response to keep
  logic [CNT_W-1:0]   out_q, out_d;           // outstanding live requests
  logic [CNT_W-1:0]   discard_q, discard_d;   // stale responses still to drop
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]        pc_q, pc_d, inst_q, inst_d;
  logic [31:0]        fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]        fifo_inst_q [FIFO_DEPTH];

  logic               fifo_empty, grant;
  logic               rsp_live, rsp_drop, rsp_keep;
  logic               push, pop, bypass, fifo_wr;
  logic [SUM_W-1:0]   credit_used;

  // Handshake and FIFO control decode.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fifo_empty  = (cnt_q == '0);
    credit_used = SUM_W'(cnt_q) + SUM_W'(out_q);
    // A response with nothing outstanding or discarding is a protocol error and is ignored.
    rsp_live    = imem_rvalid_i && ((discard_q != '0) || (out_q != '0));
    rsp_drop    = imem_rvalid_i && (discard_q != '0);
    rsp_keep    = rsp_live && !rsp_drop;
    push        = rsp_keep && !flush_i;
    // A word arriving at an empty FIFO goes straight to the output register.
    bypass      = push && fifo_empty && !stall_i;
    pop         = !flush_i && !stall_i && !fifo_empty;
    fifo_wr     = push && !bypass;
  end

  assign grant = imem_req_o && imem_gnt_i;

  // FSM output process: request while credits remain (FIFO entries plus outstanding).
  always_comb begin
    imem_req_o  = (state_q == ST_FETCH) && (credit_used < DEPTH_S) && !flush_i;
    imem_addr_o = fetch_pc_q;
  end

  // FSM next-state process.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (flush_i && (discard_d != '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (discard_d == '0) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // PC, credit, discard and FIFO pointer bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    discard_d  = discard_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (flush_i) begin
      fetch_pc_d = redirect_pc_i;
      rsp_pc_d   = redirect_pc_i;
      out_d      = '0;
      // Everything still in flight becomes stale, minus a response consumed this cycle.
      discard_d  = discard_q + out_q + CNT_W'(grant) - CNT_W'(rsp_live);
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (grant)    fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + 32'd4;
      out_d     = out_q + CNT_W'(grant) - CNT_W'(rsp_keep);
      discard_d = discard_q - CNT_W'(rsp_drop);
      cnt_d     = cnt_q + CNT_W'(fifo_wr) - CNT_W'(pop);
      if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Decode-facing output register; pc_o holds across NOP slots.
  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    if (flush_i) begin
      inst_d = '0;
    end else if (!stall_i) begin
      if (bypass) begin
        pc_d   = rsp_pc_q;
        inst_d = imem_rdata_i;
      end else if (!fifo_empty) begin
        pc_d   = fifo_pc_q[rd_ptr_q];
        inst_d = fifo_inst_q[rd_ptr_q];
      end else begin
        inst_d = '0;
      end
    end
  end

  // FSM state register and datapath state.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      discard_q  <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

  // NOTE: the FIFO array is not reset; cnt_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  assign pc_o   = pc_q;
  assign inst_o = inst_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_bubble_q, perf_bubble_d;
  logic        nop_slot;

  always_comb begin
    // A bubble is any unstalled cycle whose output load is a NOP (including a flush).
    nop_slot      = !stall_i && (flush_i || (fifo_empty && !bypass));
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if (grant && (perf_fetch_q != '1))     perf_fetch_d  = perf_fetch_q + 32'd1;
    if (nop_slot && (perf_bubble_q != '1)) perf_bubble_d = perf_bubble_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_o  = perf_fetch_q;
  assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
// The reference view: decode must see the consecutive word PCs starting at the
// reset or redirect PC, each with its memory word, frozen while stalled, with
// NOP slots in between. The memory is modelled as an in-order response queue
// with random grant and latency. The bench adds directed steps for latency,
// grant back-pressure, stall credit limit, flush of outstanding reads and PC wrap.
// ----------------------------------------------------------------------------
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, imem_gnt_i, imem_rvalid_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o, pc_o, inst_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_o, perf_bubble_o;
`endif

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_o(perf_fetch_o), .perf_bubble_o(perf_bubble_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  rsp_t        rq[$];
  int          cyc, last_ready, grants, bubbles, delivered;
  logic [31:0] exp_fetch, exp_pc, out_pc, out_inst, prev_addr, last_grant_addr;
  bit          pc_known, prev_pending, last_granted;

  // Memory contents: never zero for a word-aligned address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", imem_req_o, 1'b0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    rq.delete();
    cyc = 0; last_ready = -1; grants = 0; bubbles = 0;
    exp_fetch = RESET_PC; exp_pc = RESET_PC;
    out_pc = '0; out_inst = '0; pc_known = 1'b1; prev_pending = 1'b0;
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, model the memory, then check the decode view.
  task automatic step(input bit st, input bit fl, input logic [31:0] rpc,
                      input bit gn, input int lat);
    rsp_t r;
    int   rdy;
    stall_i = st; flush_i = fl; redirect_pc_i = rpc; imem_gnt_i = gn;
    imem_rvalid_i = 1'b0; imem_rdata_i = $urandom();
    if (rq.size() > 0 && rq[0].ready <= cyc) begin
      r = rq.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(r.addr);
    end
    #1;
    if (fl) check("req_in_flush", imem_req_o, 1'b0);
    if (prev_pending && !fl) begin
      check("req_held", imem_req_o, 1'b1);
      check("addr_held", imem_addr_o, prev_addr);
    end
    last_granted = imem_req_o && gn;
    if (last_granted) begin
      check("grant_addr", imem_addr_o, exp_fetch);
      last_grant_addr = imem_addr_o;
      rdy = (cyc + lat > last_ready + 1) ? cyc + lat : last_ready + 1;
      r.addr = imem_addr_o; r.ready = rdy;
      rq.push_back(r);
      last_ready = rdy;
      exp_fetch += 32'd4;
      grants++;
      check("credit", rq.size() <= DEPTH, 1'b1);
    end
    prev_pending = imem_req_o && !gn && !fl;
    prev_addr    = imem_addr_o;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (fl) begin
      exp_fetch = rpc;
      exp_pc    = rpc;
      check("flush_inst", inst_o, 32'h0);
      out_inst = '0; pc_known = 1'b0;
      if (!st) bubbles++;
    end else if (st) begin
      check("stall_inst", inst_o, out_inst);
      if (pc_known) check("stall_pc", pc_o, out_pc);
    end else if (inst_o !== 32'h0) begin
      check("pc", pc_o, exp_pc);
      check("inst", inst_o, mem_word(exp_pc));
      out_pc = exp_pc; out_inst = mem_word(exp_pc); pc_known = 1'b1;
      exp_pc += 32'd4;
      delivered++;
    end else begin
      bubbles++;
      out_inst = '0;
      if (pc_known) check("bubble_pc", pc_o, out_pc);
    end
  endtask

  initial begin
    int  g0, d0;
    bit  seen;
    delivered = 0;

    // Latency 1, gnt always: NOP for two cycles, then 0,4,8,... every cycle.
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1);
      if (k < 3) check("lat_nop", inst_o, 32'h0);
      else       check("lat_pc", pc_o, 32'((k - 3) * 4));
    end

    // gnt held low: request and address hold, decode sees NOPs.
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      check("nognt_req", imem_req_o, 1'b1);
      check("nognt_addr", imem_addr_o, 32'h0);
      check("nognt_inst", inst_o, 32'h0);
      step(1'b0, 1'b0, '0, 1'b0, 1);
    end

    // Stall for 6 cycles with latency 1: the credit limit allows exactly DEPTH grants.
    g0 = grants;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1, 1);
    check("stall_grants", 32'(grants - g0), 32'(DEPTH));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1);

    // Three reads outstanding at latency 4, then flush to 0x100.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 4);
    check("outstanding", 32'(rq.size()), 32'd3);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 4);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1);
      seen = (inst_o !== 32'h0);
    end
    check("flush_seen", seen, 1'b1);
    check("flush_first_pc", pc_o, 32'h0000_0100);

    // Fetch address wraps from 32'hFFFF_FFFC to 0.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1);
      seen = last_granted && (last_grant_addr == 32'hFFFF_FFFC);
    end
    check("wrap_seen", seen, 1'b1);
    check("wrap_addr", imem_addr_o, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 2);

    // Randomized traffic: stalls, flushes, sparse grants, latency 1..5.
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom() & 32'hFFFF_FFFC;
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3, rpc,
           $urandom_range(0, 9) < 6, int'($urandom_range(1, 5)));
    end
    check("progress", (delivered - d0) > 300, 1'b1);

`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch_o, 32'(grants));
    check("perf_bubble", perf_bubble_o, 32'(bubbles));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
